// File: rtl/delay_sum_beamformer_if.sv
// Stream and config bundle for delay_sum_beamformer: frame input, per-channel
// delay programming and beamformed sample output (valid/ready on both streams).
interface delay_sum_beamformer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_BITS  = 16,
  parameter int DEPTH        = 16,
  parameter int DELAY_BITS   = $clog2(DEPTH),
  parameter int CH_BITS      = $clog2(NUM_CHANNELS)
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NUM_CHANNELS*SAMPLE_BITS-1:0]   in_data;
  logic                                  cfg_valid;
  logic [CH_BITS-1:0]                    cfg_channel;
  logic [DELAY_BITS-1:0]                 cfg_delay;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [SAMPLE_BITS-1:0]                out_data;

  modport master (
    output in_valid, in_data, cfg_valid, cfg_channel, cfg_delay, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, cfg_valid, cfg_channel, cfg_delay, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel circular history, programmable delays, sequential sum.
// Optional macro BEAMFORMER_SATURATE_EN: output saturated full sum instead of the channel mean.
module delay_sum_beamformer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_BITS  = 16,
  parameter int DEPTH        = 16,
  parameter int DELAY_BITS   = $clog2(DEPTH),
  parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                   clk,
  input  logic                   reset,
  delay_sum_beamformer_if.slave  bus,
  output logic                   busy
);
  localparam int ACC_BITS  = SAMPLE_BITS + CH_BITS;
  localparam int FILL_BITS = DELAY_BITS + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                        state_q, state_d;
  logic [CH_BITS-1:0]            ch_idx_q, ch_idx_d;
  logic [DELAY_BITS-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FILL_BITS-1:0]          fill_q, fill_d;
  logic signed [ACC_BITS-1:0]    acc_q, acc_d;
  logic                          out_valid_q, out_valid_d;
  logic [SAMPLE_BITS-1:0]        out_data_q, out_data_d;
  logic [DELAY_BITS-1:0]         shadow_q [NUM_CHANNELS];
  logic [DELAY_BITS-1:0]         shadow_d [NUM_CHANNELS];
  logic [DELAY_BITS-1:0]         active_q [NUM_CHANNELS];
  logic [DELAY_BITS-1:0]         active_d [NUM_CHANNELS];

  // History is deliberately left out of reset; the fill count masks stale frames.
  logic signed [SAMPLE_BITS-1:0] hist_mem [NUM_CHANNELS][DEPTH];

  logic                          accept;
  logic [DELAY_BITS-1:0]         rd_delay;
  logic [DELAY_BITS-1:0]         rd_idx;
  logic signed [SAMPLE_BITS-1:0] rd_sample;
  logic signed [ACC_BITS-1:0]    contrib;
  logic signed [ACC_BITS-1:0]    acc_next;

`ifdef BEAMFORMER_SATURATE_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX =
    ACC_BITS'((64'sd1 <<< (SAMPLE_BITS - 1)) - 64'sd1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;
`endif

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign rd_delay  = active_q[ch_idx_q];
  assign rd_idx    = wr_ptr_q - rd_delay;
  assign rd_sample = hist_mem[ch_idx_q][rd_idx];
  // fill_q already counts the frame being summed, so delay 0 always contributes.
  assign contrib   = ({1'b0, rd_delay} >= fill_q) ? '0
                   : {{CH_BITS{rd_sample[SAMPLE_BITS-1]}}, rd_sample};
  assign acc_next  = acc_q + contrib;

  assign bus.in_ready  = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    shadow_d    = shadow_q;
    active_d    = active_q;

    // Every CH_BITS index is a real channel because the count is a power of two.
    if (bus.cfg_valid) begin
      shadow_d[bus.cfg_channel] = bus.cfg_delay;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          active_d = shadow_q;
          acc_d    = '0;
          ch_idx_d = '0;
          fill_d   = (fill_q == FILL_BITS'(DEPTH)) ? fill_q : fill_q + 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d    = acc_next;
        ch_idx_d = ch_idx_q + 1'b1;
        if (ch_idx_q == CH_BITS'(NUM_CHANNELS - 1)) begin
          wr_ptr_d    = wr_ptr_q + 1'b1;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
`ifdef BEAMFORMER_SATURATE_EN
          if (acc_next > SAT_MAX) begin
            out_data_d = SAT_MAX[SAMPLE_BITS-1:0];
          end else if (acc_next < SAT_MIN) begin
            out_data_d = SAT_MIN[SAMPLE_BITS-1:0];
          end else begin
            out_data_d = SAMPLE_BITS'(acc_next);
          end
`else
          out_data_d = SAMPLE_BITS'(acc_next >>> CH_BITS);
`endif
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_idx_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hist_mem[c][wr_ptr_q] <= bus.in_data[c*SAMPLE_BITS +: SAMPLE_BITS];
      end
    end
  end
endmodule

// File: doc/delay_sum_beamformer.md
# delay_sum_beamformer

Parametrised delay-and-sum beamforming core. It takes one signed PCM sample per channel per frame, typically from the I2S-to-PCM front ends. Each channel goes into its own circular history buffer. The block applies a run-time programmable per-channel integer-sample delay, sums the delayed samples sequentially, and emits one beamformed sample per frame over a valid/ready stream. It replaces the fixed two-channel shift-buffer path with N channels, configurable depth, and flow control.

## Interface
- NUM_CHANNELS, 4, channel count; power of two, ≥2
- SAMPLE_BITS, 16, signed two's-complement sample width
- DEPTH, 16, history frames per channel; power of two, ≥2
- DELAY_BITS, $clog2(DEPTH), delay field width
- CH_BITS, $clog2(NUM_CHANNELS), channel index width

- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  frame present on in_data
- in_ready  out  1  core can accept a frame
- in_data  in  NUM_CHANNELS*SAMPLE_BITS  channel c at [c*SAMPLE_BITS +: SAMPLE_BITS]
- cfg_valid  in  1  write cfg_delay into shadow delay of cfg_channel
- cfg_channel  in  CH_BITS  target channel
- cfg_delay  in  DELAY_BITS  delay in frames, 0..DEPTH-1
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  SAMPLE_BITS  beamformed sample, signed
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → ACCUM → OUTPUT → IDLE. in_ready = (state==IDLE). busy = !in_ready.
- IDLE, on in_valid&&in_ready:
  - write every channel sample to buf[c][wr_ptr]
  - copy all shadow delays to active delays
  - clear accumulator, set ch_idx=0, go to ACCUM
- ACCUM: one channel per cycle. Read idx = (wr_ptr − active_delay[c]) mod DEPTH. Delay 0 selects the frame just written.
  - Zero-history rule: if active_delay[c] ≥ fill_count, the contribution is 0. fill_count is the number of frames accepted, saturating at DEPTH, counting the current frame.
  - Accumulator width SAMPLE_BITS+CH_BITS, sign-extended adds, no overflow possible.
  - After channel NUM_CHANNELS−1: wr_ptr increments (wraps DEPTH−1→0), out_data is registered, out_valid goes to 1, FSM enters OUTPUT.
- OUTPUT: out_valid and out_data held stable until out_ready. On out_valid&&out_ready: out_valid goes to 0, FSM goes to IDLE.
- Config writes:
  - Accepted in any state and update the shadow register only.
  - If cfg_valid coincides with frame acceptance, the old shadow value is latched for that frame and the new value applies from the next frame.
  - cfg_channel ≥ NUM_CHANNELS is ignored.
- in_valid outside IDLE is ignored; no data is consumed.
- Reset, including mid-ACCUM or mid-OUTPUT:
  - The in-flight frame is discarded.
  - state=IDLE, out_valid=0, out_data=0, wr_ptr=0, fill_count=0, shadow and active delays=0.
  - History memory contents are not cleared; the zero-history rule masks them.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, out_data=0.
- Acceptance edge = cycle 0. ACCUM occupies cycles 1..NUM_CHANNELS. out_valid is high from cycle NUM_CHANNELS+1.
- out_ready high at the first out_valid cycle → in_ready high on the next cycle. Minimum frame period is NUM_CHANNELS+2 cycles.
- Combinational paths: none input-to-output. in_ready depends on state only.

## Configuration
- Macro: BEAMFORMER_SATURATE_EN.
- Defined: out_data = full accumulator sum, saturated to [−2^(SAMPLE_BITS−1), 2^(SAMPLE_BITS−1)−1]. Array gain is NUM_CHANNELS.
- Undefined: out_data = accumulator >>> CH_BITS, arithmetic shift, rounding toward −∞. This is the channel mean and never overflows.

## Test plan
- Reset: assert reset asynchronously mid-ACCUM → out_valid=0, in_ready=1 immediately; the next frame with all delays 0 yields a correct result unaffected by the discarded frame.
- Zero delay, N=4, frame {100,200,300,400} → out_data=250 (undefined macro) or 1000 (defined). out_valid rises exactly 5 cycles after acceptance.
- Delay: ch1 delay=2, others 0, ramp frames k = {k,k,k,k} for k=1..5.
  - Frames 1–2: ch1 contributes 0.
  - Frame 5: sum = 5+3+5+5 = 18, mean 4 (undefined macro) or 18 (defined).
- Saturation: all channels 32767 → 32767 in both builds; all channels −32768 → −32768. Defined build with {32767,32767,0,0} → 32767 clamp.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 → out_data stable, in_ready=0, no frame consumed. cfg_valid during the stall applies only to the next frame.
- Wrap: DEPTH=16, ch0 delay=15, 40 ramp frames.
  - Frames 1–15: ch0 contribution is 0.
  - From frame 16 on: ch0 contributes k−15, correct across wr_ptr wrap.
